pingpong_bank_ram: RTL and testbench
====================================

// Module: pingpong_bank_ram
// PURPOSE
//  Parametrised N-bank (ping-pong when NUM_BANKS=2) buffer RAM for the FFT datapath.
//  A producer fills one bank while a consumer reads a previously completed bank.
//  Bank ownership passes by done pulses, not by address, so the producer and consumer never touch the same bank.
//  Sits between the input sample loader and the butterfly engine, and between stages.
// PARAMETERS
//  DATA_WIDTH   32  bits per word
//  ADDR_WIDTH   10  word address width within one bank; bank depth = 2**ADDR_WIDTH
//  NUM_BANKS    2   number of banks; power of two, >= 2
//  RD_LATENCY   1   read latency in cycles, from rdEnIn to rdValidOut; 1 or 2
//  BANK_W       $clog2(NUM_BANKS), derived
// PORTS
//  clkIn        in   1           single clock; all logic on posedge
//  rstNIn       in   1           asynchronous, active-low reset
//  wrEnIn       in   1           write strobe
//  wrAddrIn     in   ADDR_WIDTH  word address in the current write bank
//  wrDataIn     in   DATA_WIDTH  write data
//  wrDoneIn     in   1           pulse: current write bank complete, hand it to the reader
//  wrReadyOut   out  1           a bank is free for writing
//  wrBankOut    out  BANK_W      index of the current write bank
//  rdEnIn       in   1           read strobe
//  rdAddrIn     in   ADDR_WIDTH  word address in the current read bank
//  rdDoneIn     in   1           pulse: current read bank consumed, release it
//  rdReadyOut   out  1           a completed bank is available for reading
//  rdBankOut    out  BANK_W      index of the current read bank
//  rdDataOut    out  DATA_WIDTH  read data
//  rdValidOut   out  1           rdDataOut valid this cycle
//  fullCntOut   out  BANK_W+1    number of completed, unreleased banks (0..NUM_BANKS)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - wrBank=0, rdBank=0, fullCnt=0; rdDataOut=0, rdValidOut=0 (entire read pipeline cleared)
//   - Outputs: wrReadyOut=1, rdReadyOut=0
//   - Memory contents are not reset. Asserting reset mid-operation discards every bank and in-flight read.
//  Ready flags (combinational from registered state):
//   - wrReadyOut = (fullCnt < NUM_BANKS)
//   - rdReadyOut = (fullCnt > 0)
//  Storage: single array of NUM_BANKS*2**ADDR_WIDTH words. Physical address = {bank, addr}.
//  Write:
//   - If wrEnIn && wrReadyOut: mem[{wrBank,wrAddrIn}] <= wrDataIn.
//   - wrEnIn while !wrReadyOut is dropped; no memory change.
//  Read:
//   - If rdEnIn && rdReadyOut: mem[{rdBank,rdAddrIn}] is sampled that edge.
//   - RD_LATENCY=1: rdDataOut/rdValidOut appear the next cycle. RD_LATENCY=2: an extra output register stage is added.
//   - rdEnIn while !rdReadyOut is dropped; rdValidOut stays 0 for that slot.
//   - rdDataOut holds its last value while rdValidOut=0.
//   - Fully pipelined: one read accepted per cycle.
//  Handoff:
//   - Accepted wrDone (wrDoneIn && wrReadyOut): wrBank <= wrBank+1 (mod NUM_BANKS).
//   - Accepted rdDone (rdDoneIn && rdReadyOut): rdBank <= rdBank+1 (mod NUM_BANKS).
//   - fullCnt <= fullCnt + acceptedWrDone - acceptedRdDone.
//   - Simultaneous accepted wrDone and rdDone: both pointers advance, fullCnt unchanged.
//   - Unaccepted done pulses are ignored with no state change.
//   - Write and wrDone in the same cycle: the write lands in the old bank. The same rule applies to read and rdDone.
//   - Reads already in the pipeline complete normally after rdDone.
//  Invariant: when wrReadyOut && rdReadyOut, wrBank != rdBank, so no same-word read/write collision is possible.
//   - A bench assertion flags any violation.
//  Wrap-around: pointers wrap NUM_BANKS-1 -> 0. fullCnt never exceeds NUM_BANKS and never goes below 0.
// TESTING
//  1. Reset, then idle -> wrReadyOut=1, rdReadyOut=0, fullCntOut=0, rdValidOut=0, rdDataOut=0.
//  2. Fill bank0 with data=addr+0x100 for addr 0..1023, pulse wrDone -> fullCnt=1, wrBank=1, rdReady=1.
//     Read addr 5 -> rdDataOut=0x105 after RD_LATENCY cycles with rdValidOut=1.
//  3. NUM_BANKS=2: two wrDone pulses with no rdDone -> wrReadyOut=0.
//     A further write to addr 0 of 0xDEAD is dropped; a third wrDone is ignored; fullCnt stays 2.
//  4. fullCnt=1; wrDone and rdDone in the same cycle -> fullCnt stays 1, both banks advance.
//     Read back the new bank's data correctly.
//  5. Back-to-back reads addr 0..7 with rdDone on the last read -> 8 consecutive valid words, correct values.
//     rdBank advances after the final issue.
//  6. Assert rstNIn low mid-fill with reads in flight -> outputs return to reset values asynchronously.
//     No rdValidOut pulses after release.

Source files
------------

// File: rtl/pingpong_bank_ram.sv
// N-bank ping-pong buffer RAM: a producer fills one bank while a consumer reads a completed one.
// Bank ownership moves only on accepted done pulses; fullCntOut counts completed, unreleased banks.
module pingpong_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS  = 2,
  parameter int RD_LATENCY = 1,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                  clkIn,
  input  logic                  rstNIn,
  input  logic                  wrEnIn,
  input  logic [ADDR_WIDTH-1:0] wrAddrIn,
  input  logic [DATA_WIDTH-1:0] wrDataIn,
  input  logic                  wrDoneIn,
  output logic                  wrReadyOut,
  output logic [BANK_W-1:0]     wrBankOut,
  input  logic                  rdEnIn,
  input  logic [ADDR_WIDTH-1:0] rdAddrIn,
  input  logic                  rdDoneIn,
  output logic                  rdReadyOut,
  output logic [BANK_W-1:0]     rdBankOut,
  output logic [DATA_WIDTH-1:0] rdDataOut,
  output logic                  rdValidOut,
  output logic [BANK_W:0]       fullCntOut
);

  localparam int              DEPTH     = NUM_BANKS * (2 ** ADDR_WIDTH);
  localparam logic [BANK_W:0] CNT_MAX   = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [BANK_W:0] CNT_ZERO  = {(BANK_W + 1){1'b0}};
  localparam logic [BANK_W:0] CNT_ONE   = (BANK_W + 1)'(1);
  localparam logic [BANK_W-1:0] BANK_ONE = BANK_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [BANK_W-1:0]     r_wr_bank;
  logic [BANK_W-1:0]     r_rd_bank;
  logic [BANK_W:0]       r_full_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data1;
  logic                  r_rd_valid1;

  logic            w_wr_ready;
  logic            w_rd_ready;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_wr_done_acc;
  logic            w_rd_done_acc;
  logic [BANK_W:0] w_full_cnt_nxt;

  assign w_wr_ready    = (r_full_cnt < CNT_MAX);
  assign w_rd_ready    = (r_full_cnt != CNT_ZERO);
  assign w_wr_acc      = wrEnIn & w_wr_ready;
  assign w_rd_acc      = rdEnIn & w_rd_ready;
  assign w_wr_done_acc = wrDoneIn & w_wr_ready;
  assign w_rd_done_acc = rdDoneIn & w_rd_ready;

  assign wrReadyOut = w_wr_ready;
  assign rdReadyOut = w_rd_ready;
  assign wrBankOut  = r_wr_bank;
  assign rdBankOut  = r_rd_bank;
  assign fullCntOut = r_full_cnt;

  // Occupancy update: a simultaneous handoff on both sides leaves the count unchanged.
  always_comb begin
    w_full_cnt_nxt = r_full_cnt;
    case ({w_wr_done_acc, w_rd_done_acc})
      2'b10:   w_full_cnt_nxt = r_full_cnt + CNT_ONE;
      2'b01:   w_full_cnt_nxt = r_full_cnt - CNT_ONE;
      default: w_full_cnt_nxt = r_full_cnt;
    endcase
  end

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clkIn) begin
    if (w_wr_acc) begin
      r_mem[{r_wr_bank, wrAddrIn}] <= wrDataIn;
    end
  end

  // Bank pointers and occupancy; pointers wrap naturally because NUM_BANKS is a power of two.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_wr_bank  <= {BANK_W{1'b0}};
      r_rd_bank  <= {BANK_W{1'b0}};
      r_full_cnt <= CNT_ZERO;
    end else begin
      if (w_wr_done_acc) begin
        r_wr_bank <= r_wr_bank + BANK_ONE;
      end
      if (w_rd_done_acc) begin
        r_rd_bank <= r_rd_bank + BANK_ONE;
      end
      r_full_cnt <= w_full_cnt_nxt;
    end
  end

  // First read stage: sample the word of the current read bank; data holds when idle.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_rd_data1  <= {DATA_WIDTH{1'b0}};
      r_rd_valid1 <= 1'b0;
    end else begin
      r_rd_valid1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data1 <= r_mem[{r_rd_bank, rdAddrIn}];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_rd_data2;
      logic                  r_rd_valid2;

      // Optional output register stage for timing.
      always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
          r_rd_data2  <= {DATA_WIDTH{1'b0}};
          r_rd_valid2 <= 1'b0;
        end else begin
          r_rd_valid2 <= r_rd_valid1;
          if (r_rd_valid1) begin
            r_rd_data2 <= r_rd_data1;
          end
        end
      end

      assign rdDataOut  = r_rd_data2;
      assign rdValidOut = r_rd_valid2;
    end else begin : g_lat1
      assign rdDataOut  = r_rd_data1;
      assign rdValidOut = r_rd_valid1;
    end
  endgenerate

endmodule

// File: tb/tb_pingpong_bank_ram.sv
// Scoreboard bench for pingpong_bank_ram: reads push expected words, a negedge monitor pops and compares.
module tb_pingpong_bank_ram;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = 2;
  localparam int RL = 1;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_done = 1'b0;
  logic          wr_ready;
  logic [BW-1:0] wr_bank;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_done = 1'b0;
  logic          rd_ready;
  logic [BW-1:0] rd_bank;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [BW:0]   full_cnt;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int unexp = 0;
  int run_len = 0;
  int max_run = 0;
  logic [DW-1:0] exp_q[$];

  pingpong_bank_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RD_LATENCY(RL)) dut (
    .clkIn(clk), .rstNIn(rst_n),
    .wrEnIn(wr_en), .wrAddrIn(wr_addr), .wrDataIn(wr_data), .wrDoneIn(wr_done),
    .wrReadyOut(wr_ready), .wrBankOut(wr_bank),
    .rdEnIn(rd_en), .rdAddrIn(rd_addr), .rdDoneIn(rd_done),
    .rdReadyOut(rd_ready), .rdBankOut(rd_bank),
    .rdDataOut(rd_data), .rdValidOut(rd_valid), .fullCntOut(full_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic rd_issue(input int a, input logic [DW-1:0] exp, input logic done);
    rd_en = 1'b1; rd_addr = AW'(a); rd_done = done;
    exp_q.push_back(exp);
    tick();
    clear_in();
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk(nm, exp_q.size(), 0);
    tick();
  endtask

  // Monitor: pop on every valid output and check the bank-collision invariant.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        errors++;
        unexp++;
        $display("FAIL unexpected_valid: got rdDataOut=%0h with no read outstanding", rd_data);
      end else begin
        automatic logic [DW-1:0] e = exp_q.pop_front();
        pops++;
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end else begin
      run_len = 0;
    end
    if (rst_n && wr_ready && rd_ready && (wr_bank == rd_bank)) begin
      errors++;
      $display("FAIL bank_collision: wrBank=%0d rdBank=%0d", wr_bank, rd_bank);
    end
  end

  initial begin
    int p0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1. reset state
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_full_cnt", full_cnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);

    // read while empty is dropped
    rd_en = 1'b1; rd_addr = 10'd5;
    tick();
    clear_in();
    chk("drop_rd_valid", rd_valid, 0);

    // 2. fill bank0, wrDone together with the last write (lands in bank0)
    for (int a = 0; a < 1024; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h100 + 32'(a);
      wr_done = (a == 1023);
      tick();
    end
    clear_in();
    chk("t2_full_cnt", full_cnt, 1);
    chk("t2_wr_bank", wr_bank, 1);
    chk("t2_rd_ready", rd_ready, 1);
    chk("t2_rd_bank", rd_bank, 0);
    rd_issue(5, 32'h105, 1'b0);
    rd_issue(1023, 32'h4FF, 1'b0);
    drain("t2_drain");

    // 3. fill bank1 -> both full, further write and wrDone dropped
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h200 + 32'(a);
      wr_done = (a == 7);
      tick();
    end
    clear_in();
    chk("t3_full_cnt", full_cnt, 2);
    chk("t3_wr_ready", wr_ready, 0);
    chk("t3_wr_bank", wr_bank, 0);
    wr_en = 1'b1; wr_addr = 10'd0; wr_data = 32'hDEAD;
    tick();
    clear_in();
    wr_done = 1'b1;
    tick();
    clear_in();
    chk("t3_full_cnt_hold", full_cnt, 2);
    chk("t3_wr_bank_hold", wr_bank, 0);
    rd_issue(0, 32'h100, 1'b0);
    drain("t3_drain");
    rd_done = 1'b1;
    tick();
    clear_in();
    chk("t3_rel_full_cnt", full_cnt, 1);
    chk("t3_rel_rd_bank", rd_bank, 1);
    chk("t3_rel_wr_ready", wr_ready, 1);

    // 4. refill bank0 then simultaneous wrDone and rdDone
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h300 + 32'(a);
      tick();
    end
    clear_in();
    wr_done = 1'b1; rd_done = 1'b1;
    tick();
    clear_in();
    chk("t4_full_cnt", full_cnt, 1);
    chk("t4_wr_bank", wr_bank, 1);
    chk("t4_rd_bank", rd_bank, 0);
    rd_issue(3, 32'h303, 1'b0);
    drain("t4_drain");

    // 5. back-to-back reads with rdDone on the last issue
    p0 = pops;
    max_run = 0;
    rd_en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a); rd_done = (a == 7);
      exp_q.push_back(32'h300 + 32'(a));
      tick();
    end
    clear_in();
    drain("t5_drain");
    chk("t5_pop_count", pops - p0, 8);
    chk("t5_consecutive", max_run, 8);
    chk("t5_rd_bank", rd_bank, 1);
    chk("t5_full_cnt", full_cnt, 0);
    chk("t5_rd_ready", rd_ready, 0);
    chk("t5_rd_data_hold", rd_data, 32'h307);

    // 6. reset mid-fill with reads in flight
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h400 + 32'(a);
      wr_done = (a == 3);
      tick();
    end
    clear_in();
    chk("t6_rd_ready", rd_ready, 1);
    for (int a = 0; a < 3; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h500 + 32'(a);
      rd_en = 1'b1; rd_addr = AW'(a);
      exp_q.push_back(32'h400 + 32'(a));
      tick();
    end
    clear_in();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_full_cnt", full_cnt, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_rd_ready", rd_ready, 0);
    chk("t6_wr_bank", wr_bank, 0);
    chk("t6_rd_bank", rd_bank, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    p0 = pops;
    repeat (10) tick();
    chk("t6_no_valid_after", pops - p0, 0);
    chk("t6_unexpected", unexp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
